// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit driving a word-wide DMEM with byte/half extract and RMW
// Optional misaligned-access error path: define DMEM_LSU_MISALIGN_ERR_EN
module dmem_lsu #(
    parameter int ADDR_DEPTH = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_UNSIGNED,
    input  logic [31:0]           REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [31:0]           RSP_DATA,
    output logic                  RSP_ERR,
    output logic                  MEM_RDEN,
    output logic                  MEM_WEN,
    output logic [1:0]            MEM_BYTE_SEL,
    output logic                  MEM_SIGN,
    output logic [ADDR_DEPTH-1:0] MEM_ADDR,
    output logic [31:0]           MEM_DIN,
    input  logic [31:0]           MEM_DOUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD_CAP,
        S_MERGE,
        S_WR,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [15:0] r_wlo;

    logic        accept;
    logic        is_word;
    logic        misaligned;
    logic        take_err;
    logic [1:0]  lane_in;

    logic                  rden_d;
    logic                  wen_d;
    logic                  rsp_valid_d;
    logic                  rsp_err_d;
    logic [31:0]           rsp_data_d;
    logic [31:0]           din_d;
    logic [ADDR_DEPTH-1:0] addr_d;
    logic [31:0]           merged;
    logic [31:0]           load_ext;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    logic unused_addr_bits;
    assign unused_addr_bits = ^REQ_ADDR[31:ADDR_DEPTH+2];

    assign REQ_READY    = (state == S_IDLE);
    assign accept       = REQ_VALID && REQ_READY;
    assign is_word      = REQ_SIZE[1];
    assign misaligned   = ((REQ_SIZE == 2'b01) && REQ_ADDR[0]) ||
                          (is_word && (REQ_ADDR[1:0] != 2'b00));
    assign MEM_BYTE_SEL = 2'b10;
    assign MEM_SIGN     = 1'b0;

`ifdef DMEM_LSU_MISALIGN_ERR_EN
    assign take_err = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign take_err          = 1'b0;
`endif

    // Lane is force-aligned here; with the error path enabled misaligned requests never use it.
    always_comb begin
        lane_in = 2'b00;
        case (REQ_SIZE)
            2'b00:   lane_in = REQ_ADDR[1:0];
            2'b01:   lane_in = {REQ_ADDR[1], 1'b0};
            default: lane_in = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we   <= 1'b0;
            r_uns  <= 1'b0;
            r_size <= 2'b00;
            r_lane <= 2'b00;
            r_wlo  <= 16'h0000;
        end else if (accept) begin
            r_we   <= REQ_WE;
            r_uns  <= REQ_UNSIGNED;
            r_size <= REQ_SIZE;
            r_lane <= lane_in;
            r_wlo  <= REQ_WDATA[15:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (take_err) begin
                        state_nxt = S_ERR;
                    end else if (REQ_WE && is_word) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD:     state_nxt = r_we ? S_MERGE : S_LD_CAP;
            S_LD_CAP: state_nxt = S_IDLE;
            S_MERGE:  state_nxt = S_WR;
            S_WR:     state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Lane extraction and merge both work on the DMEM word that arrives one cycle after RDEN.
    always_comb begin
        ld_byte = MEM_DOUT[{r_lane, 3'b000} +: 8];
        ld_half = MEM_DOUT[{r_lane[1], 4'b0000} +: 16];
        merged  = MEM_DOUT;
        case (r_size)
            2'b00: begin
                load_ext = {{24{ld_byte[7] & ~r_uns}}, ld_byte};
                merged[{r_lane, 3'b000} +: 8] = r_wlo[7:0];
            end
            2'b01: begin
                load_ext = {{16{ld_half[15] & ~r_uns}}, ld_half};
                merged[{r_lane[1], 4'b0000} +: 16] = r_wlo;
            end
            default: begin
                load_ext = MEM_DOUT;
            end
        endcase
    end

    always_comb begin
        rden_d      = (state_nxt == S_RD);
        wen_d       = (state_nxt == S_WR);
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = 32'h0000_0000;
        din_d       = MEM_DIN;
        addr_d      = accept ? REQ_ADDR[ADDR_DEPTH+1:2] : MEM_ADDR;
        case (state)
            S_IDLE: begin
                if (state_nxt == S_WR) begin
                    din_d = REQ_WDATA;
                end
                if (state_nxt == S_ERR) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            S_LD_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = load_ext;
            end
            S_MERGE: begin
                din_d = merged;
            end
            S_WR: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_RDEN  <= 1'b0;
            MEM_WEN   <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_DIN   <= 32'h0000_0000;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_DATA  <= 32'h0000_0000;
        end else begin
            MEM_RDEN  <= rden_d;
            MEM_WEN   <= wen_d;
            MEM_ADDR  <= addr_d;
            MEM_DIN   <= din_d;
            RSP_VALID <= rsp_valid_d;
            RSP_ERR   <= rsp_err_d;
            RSP_DATA  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - scoreboard testbench for dmem_lsu with a behavioural DMEM and reference memory
`timescale 1ns/1ps
module tb_dmem_lsu;

    localparam int AD = 14;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [1:0]    REQ_SIZE = 2'b00;
    logic          REQ_UNSIGNED = 1'b0;
    logic [31:0]   REQ_ADDR = 32'h0;
    logic [31:0]   REQ_WDATA = 32'h0;
    logic          RSP_VALID;
    logic [31:0]   RSP_DATA;
    logic          RSP_ERR;
    logic          MEM_RDEN;
    logic          MEM_WEN;
    logic [1:0]    MEM_BYTE_SEL;
    logic          MEM_SIGN;
    logic [AD-1:0] MEM_ADDR;
    logic [31:0]   MEM_DIN;
    logic [31:0]   mem_dout;

    dmem_lsu #(.ADDR_DEPTH(AD)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .MEM_RDEN(MEM_RDEN), .MEM_WEN(MEM_WEN), .MEM_BYTE_SEL(MEM_BYTE_SEL),
        .MEM_SIGN(MEM_SIGN), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(mem_dout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [1:0]    kind;
        logic [AD-1:0] addr;
        logic [31:0]   din;
    } mop_t;

    rsp_t rsp_q[$];
    mop_t mop_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    bit [31:0] dmem    [0:(1<<AD)-1];
    bit [31:0] ref_mem [0:(1<<AD)-1];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MEM_WEN) dmem[MEM_ADDR] <= MEM_DIN;
        if (MEM_RDEN) mem_dout <= dmem[MEM_ADDR];
    end

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lane);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (8 * lane)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] mask;
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * lane);
        return (w & ~mask) | ((wd << (8 * lane)) & mask);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic scramble_idle();
        REQ_VALID    = 1'b0;
        REQ_WE       = 1'($urandom);
        REQ_SIZE     = 2'($urandom);
        REQ_UNSIGNED = 1'($urandom);
        REQ_ADDR     = $urandom;
        REQ_WDATA    = $urandom;
    endtask

    // abort: the request will be killed by reset after its read, so only the read is expected.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit abort);
        int          n;
        logic [1:0]  lane;
        logic [AD-1:0] widx;
        logic [31:0] w;
        logic [31:0] m;
        bit          mis;
        bit          err;
        @(negedge CLK);
        REQ_WE = we; REQ_SIZE = size; REQ_UNSIGNED = uns; REQ_ADDR = addr; REQ_WDATA = wdata;
        REQ_VALID = 1'b1;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (REQ_READY !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: REQ_READY stuck low for %0d cycles, required 1", n);
            scramble_idle();
            return;
        end
        widx = addr[AD+1:2];
        lane = addr[1:0];
        mis  = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0);
        err  = 1'b0;
`ifdef DMEM_LSU_MISALIGN_ERR_EN
        err = mis;
`endif
        if (size == 2'd1) lane = lane & 2'b10;
        if (size >= 2'd2) lane = 2'b00;
        w = ref_mem[widx];
        if (abort) begin
            mop_q.push_back('{2'b10, widx, 32'h0});
        end else if (err) begin
            rsp_q.push_back('{32'h0, 1'b1, cyc + 1});
        end else if (!we) begin
            mop_q.push_back('{2'b10, widx, 32'h0});
            rsp_q.push_back('{load_model(w, size, uns, lane), 1'b0, cyc + 3});
        end else if (size >= 2'd2) begin
            mop_q.push_back('{2'b01, widx, wdata});
            ref_mem[widx] = wdata;
            rsp_q.push_back('{32'h0, 1'b0, cyc + 2});
        end else begin
            m = store_model(w, size, lane, wdata);
            mop_q.push_back('{2'b10, widx, 32'h0});
            mop_q.push_back('{2'b01, widx, m});
            ref_mem[widx] = m;
            rsp_q.push_back('{32'h0, 1'b0, cyc + 4});
        end
        @(posedge CLK);
        #1;
        scramble_idle();
    endtask

    initial begin : mon_rsp
        rsp_t e;
        forever begin
            @(negedge CLK);
            if (RSP_VALID === 1'b1) begin
                n_cmp++;
                if (rsp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_unexpected: RSP_VALID at cycle %0d, required no response", cyc);
                end else begin
                    e = rsp_q.pop_front();
                    if (RSP_DATA !== e.data || RSP_ERR !== e.err || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL rsp: got data=0x%08h err=%0b cycle=%0d, required data=0x%08h err=%0b cycle=%0d",
                                 RSP_DATA, RSP_ERR, cyc, e.data, e.err, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : mon_mem
        mop_t e;
        forever begin
            @(negedge CLK);
            if (MEM_RDEN === 1'b1 || MEM_WEN === 1'b1) begin
                n_cmp++;
                if (mop_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL mem_unexpected: rden=%0b wen=%0b at cycle %0d, required no access",
                             MEM_RDEN, MEM_WEN, cyc);
                end else begin
                    e = mop_q.pop_front();
                    if ({MEM_RDEN, MEM_WEN} !== e.kind || MEM_ADDR !== e.addr ||
                        (e.kind == 2'b01 && MEM_DIN !== e.din)) begin
                        n_bad++;
                        $display("FAIL mem_access: got rden/wen=%b addr=0x%0h din=0x%08h, required rden/wen=%b addr=0x%0h din=0x%08h",
                                 {MEM_RDEN, MEM_WEN}, MEM_ADDR, MEM_DIN, e.kind, e.addr, e.din);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [31:0] saved;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_req_ready", 32'(REQ_READY), 32'h1);
        chk("reset_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("reset_rsp_err", 32'(RSP_ERR), 32'h0);
        chk("reset_rsp_data", RSP_DATA, 32'h0);
        chk("reset_mem_rden", 32'(MEM_RDEN), 32'h0);
        chk("reset_mem_wen", 32'(MEM_WEN), 32'h0);
        chk("reset_mem_addr", 32'(MEM_ADDR), 32'h0);
        chk("reset_mem_din", MEM_DIN, 32'h0);
        chk("mem_byte_sel", 32'(MEM_BYTE_SEL), 32'h2);
        chk("mem_sign", 32'(MEM_SIGN), 32'h0);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h23, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h15, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'hABCD_0014, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
            issue(1'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63)), $urandom, 1'b0);
        end

        n = 0;
        while ((rsp_q.size() != 0 || mop_q.size() != 0) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_rsp_outstanding", 32'(rsp_q.size()), 32'h0);
        chk("drain_mem_outstanding", 32'(mop_q.size()), 32'h0);

        saved = ref_mem[1];
        issue(1'b1, 2'd0, 1'b0, 32'h4, 32'h0000_0077, 1'b1);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_req_ready", 32'(REQ_READY), 32'h1);
        chk("rst_mid_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rst_mid_mem_wen", 32'(MEM_WEN), 32'h0);
        repeat (4) @(negedge CLK);
        chk("rst_mid_word_unchanged", dmem[1], saved);
        chk("rst_mid_mem_outstanding", 32'(mop_q.size()), 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, 1'b0);

        n = 0;
        while ((rsp_q.size() != 0 || mop_q.size() != 0) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("final_rsp_outstanding", 32'(rsp_q.size()), 32'h0);
        chk("final_mem_outstanding", 32'(mop_q.size()), 32'h0);
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
